mc_ctrl: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 101 ++++++++++
 rtl/mc_ctrl_if.sv | 36 +++
 rtl/mc_ctrl_alu_dec.sv | 58 +++++
 rtl/mc_ctrl.sv | 150 +++++++++++++++
 tb/tb_mc_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS main controller
// Holds ALUOp_* codes, state codes, opcode/funct constants, operand-B and
// next-PC select encodings, the latched instruction class and its decoder.
package mc_ctrl_pkg;

  // ALU operation codes driven on AluCtrl
  localparam logic [4:0] ALUOp_NOP  = 5'd0;
  localparam logic [4:0] ALUOp_ADD  = 5'd1;
  localparam logic [4:0] ALUOp_ADDU = 5'd2;
  localparam logic [4:0] ALUOp_SUB  = 5'd3;
  localparam logic [4:0] ALUOp_SUBU = 5'd4;
  localparam logic [4:0] ALUOp_AND  = 5'd5;
  localparam logic [4:0] ALUOp_OR   = 5'd6;
  localparam logic [4:0] ALUOp_SLT  = 5'd7;
  localparam logic [4:0] ALUOp_SLL  = 5'd8;
  localparam logic [4:0] ALUOp_SRL  = 5'd9;
  localparam logic [4:0] ALUOp_EQL  = 5'd10;
  localparam logic [4:0] ALUOp_BNE  = 5'd11;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;

  // AluSrcB selects
  localparam logic [2:0] SRCB_REG    = 3'd0;
  localparam logic [2:0] SRCB_FOUR   = 3'd1;
  localparam logic [2:0] SRCB_SEXT   = 3'd2;
  localparam logic [2:0] SRCB_ZEXT   = 3'd3;
  localparam logic [2:0] SRCB_BRANCH = 3'd4;

  // PCSrc selects
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } mcState_e;

  typedef enum logic [3:0] {
    CL_NONE = 4'd0,
    CL_R,
    CL_ADDI,
    CL_ADDIU,
    CL_ORI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_BNE,
    CL_J,
    CL_ILL
  } instrClass_e;

  // Any opcode or R-type funct not listed maps to CL_ILL.
  function automatic instrClass_e decodeClass(input logic [5:0] op, input logic [5:0] funct);
    instrClass_e cls;
    cls = CL_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: cls = CL_R;
          default: cls = CL_ILL;
        endcase
      end
      OP_LW:    cls = CL_LW;
      OP_SW:    cls = CL_SW;
      OP_BEQ:   cls = CL_BEQ;
      OP_BNE:   cls = CL_BNE;
      OP_J:     cls = CL_J;
      OP_ADDI:  cls = CL_ADDI;
      OP_ADDIU: cls = CL_ADDIU;
      OP_ORI:   cls = CL_ORI;
      default:  cls = CL_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control/status bundle between mc_ctrl and the datapath
// master: controller side (drives enables/selects, reads Op/Funct/Zero/MemReady)
// slave:  datapath side
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;

  logic       PCWr;
  logic [1:0] PCSrc;
  logic       IRWr;
  logic       MemRd;
  logic       MemWr;
  logic       IorD;
  logic       RegWr;
  logic       RegDst;
  logic       MemToReg;
  logic       AluSrcA;
  logic [2:0] AluSrcB;
  logic [4:0] AluCtrl;
  logic       IllegalOp;
  logic [2:0] State;

  modport master (
    input  Op, Funct, Zero, MemReady,
    output PCWr, PCSrc, IRWr, MemRd, MemWr, IorD, RegWr, RegDst, MemToReg,
           AluSrcA, AluSrcB, AluCtrl, IllegalOp, State
  );

  modport slave (
    output Op, Funct, Zero, MemReady,
    input  PCWr, PCSrc, IRWr, MemRd, MemWr, IorD, RegWr, RegDst, MemToReg,
           AluSrcA, AluSrcB, AluCtrl, IllegalOp, State
  );
endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// rtl/mc_ctrl_alu_dec.sv - EXEC-state ALU operation and operand-select decode
// Ports: instrClass (latched class), funct (IR[5:0]) in;
//        aluCtrl, aluSrcA, aluSrcB out. Purely combinational.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  instrClass_e instrClass,
  input  logic [5:0]  funct,
  output logic [4:0]  aluCtrl,
  output logic        aluSrcA,
  output logic [2:0]  aluSrcB
);

  always_comb begin
    aluCtrl = ALUOp_ADDU;
    aluSrcA = 1'b1;
    aluSrcB = SRCB_REG;
    case (instrClass)
      CL_R: begin
        case (funct)
          FN_ADD:  aluCtrl = ALUOp_ADD;
          FN_ADDU: aluCtrl = ALUOp_ADDU;
          FN_SUB:  aluCtrl = ALUOp_SUB;
          FN_SUBU: aluCtrl = ALUOp_SUBU;
          FN_AND:  aluCtrl = ALUOp_AND;
          FN_OR:   aluCtrl = ALUOp_OR;
          FN_SLT:  aluCtrl = ALUOp_SLT;
          // Shift amount sits in imm[10:6], so route the immediate to port B.
          FN_SLL: begin
            aluCtrl = ALUOp_SLL;
            aluSrcB = SRCB_SEXT;
          end
          FN_SRL: begin
            aluCtrl = ALUOp_SRL;
            aluSrcB = SRCB_SEXT;
          end
          default: aluCtrl = ALUOp_ADDU;
        endcase
      end
      CL_ADDI: begin
        aluCtrl = ALUOp_ADD;
        aluSrcB = SRCB_SEXT;
      end
      CL_ADDIU, CL_LW, CL_SW: begin
        aluCtrl = ALUOp_ADDU;
        aluSrcB = SRCB_SEXT;
      end
      CL_ORI: begin
        aluCtrl = ALUOp_OR;
        aluSrcB = SRCB_ZEXT;
      end
      CL_BEQ:  aluCtrl = ALUOp_EQL;
      CL_BNE:  aluCtrl = ALUOp_BNE;
      default: aluCtrl = ALUOp_ADDU;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS main controller (FETCH/DECODE/EXEC/MEM/WB)
// Ports: clk, rst (sync, active-high); bus (mc_ctrl_if.master) carrying
//        Op/Funct/Zero/MemReady in and PC/IR/memory/register-file enables,
//        ALU selects, AluCtrl, IllegalOp and State out.
// Macro MC_CTRL_MEM_WAIT_EN: FETCH and MEM hold until MemReady=1.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  mc_ctrl_if.master bus
);

  mcState_e    state, stateNext;
  instrClass_e instrClass, classNext;
  instrClass_e decodedClass;

  logic       pcWr, irWr, memRd, memWr, iorD, regWr, regDst, memToReg;
  logic       aluSrcA, illegalOp;
  logic [1:0] pcSrc;
  logic [2:0] aluSrcB;
  logic [4:0] aluCtrl;

  logic [4:0] decAluCtrl;
  logic       decAluSrcA;
  logic [2:0] decAluSrcB;
  logic       memDone;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign memDone = bus.MemReady;
`else
  // Memory always completes in one cycle; MemReady has no effect here.
  logic unusedMemReady;
  assign memDone        = 1'b1;
  assign unusedMemReady = bus.MemReady;
`endif

  // Op/Funct are only meaningful once IR has been loaded, i.e. from DECODE on.
  assign decodedClass = decodeClass(bus.Op, bus.Funct);

  mc_alu_dec u_aluDec (
    .instrClass(instrClass),
    .funct     (bus.Funct),
    .aluCtrl   (decAluCtrl),
    .aluSrcA   (decAluSrcA),
    .aluSrcB   (decAluSrcB)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      instrClass <= CL_NONE;
    end else begin
      state      <= stateNext;
      instrClass <= classNext;
    end
  end

  always_comb begin
    stateNext = state;
    classNext = instrClass;
    pcWr      = 1'b0;
    pcSrc     = PCSRC_ALU;
    irWr      = 1'b0;
    memRd     = 1'b0;
    memWr     = 1'b0;
    iorD      = 1'b0;
    regWr     = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_REG;
    aluCtrl   = ALUOp_ADDU;
    illegalOp = 1'b0;

    // While rst is high every output stays at its idle value, so a reset
    // landing mid-instruction cannot leak a write.
    if (!rst) begin
      case (state)
        S_FETCH: begin
          memRd   = 1'b1;
          aluSrcB = SRCB_FOUR;
          irWr    = memDone;
          pcWr    = memDone;
          if (memDone) stateNext = S_DECODE;
        end
        S_DECODE: begin
          classNext = decodedClass;
          aluSrcB   = SRCB_BRANCH;
          case (decodedClass)
            CL_J: begin
              pcWr      = 1'b1;
              pcSrc     = PCSRC_JUMP;
              stateNext = S_FETCH;
            end
            CL_ILL: begin
              illegalOp = 1'b1;
              stateNext = S_FETCH;
            end
            default: stateNext = S_EXEC;
          endcase
        end
        S_EXEC: begin
          aluCtrl = decAluCtrl;
          aluSrcA = decAluSrcA;
          aluSrcB = decAluSrcB;
          case (instrClass)
            CL_LW, CL_SW: stateNext = S_MEM;
            CL_BEQ, CL_BNE: begin
              // ALU is combinational: Zero is valid in this same cycle.
              pcWr      = bus.Zero;
              pcSrc     = PCSRC_ALUOUT;
              stateNext = S_FETCH;
            end
            default: stateNext = S_WB;
          endcase
        end
        S_MEM: begin
          iorD  = 1'b1;
          memRd = (instrClass == CL_LW);
          memWr = (instrClass == CL_SW);
          if (memDone) stateNext = (instrClass == CL_LW) ? S_WB : S_FETCH;
        end
        S_WB: begin
          regWr     = 1'b1;
          regDst    = (instrClass == CL_R);
          memToReg  = (instrClass == CL_LW);
          stateNext = S_FETCH;
        end
        default: stateNext = S_FETCH;
      endcase
    end
  end

  assign bus.PCWr      = pcWr;
  assign bus.PCSrc     = pcSrc;
  assign bus.IRWr      = irWr;
  assign bus.MemRd     = memRd;
  assign bus.MemWr     = memWr;
  assign bus.IorD      = iorD;
  assign bus.RegWr     = regWr;
  assign bus.RegDst    = regDst;
  assign bus.MemToReg  = memToReg;
  assign bus.AluSrcA   = aluSrcA;
  assign bus.AluSrcB   = aluSrcB;
  assign bus.AluCtrl   = aluCtrl;
  assign bus.IllegalOp = illegalOp;
  assign bus.State     = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_J = 6, K_ILL = 7;
  localparam int I_ADDU = 1, I_LW = 12, I_SW = 13, I_BEQ = 14, I_BNE = 15, I_ILL = 17;

`ifdef MC_CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    int         kind;
    logic [4:0] alu;
    logic [2:0] srcB;
  } instrDesc_t;

  typedef struct packed {
    logic       pcWr;
    logic [1:0] pcSrc;
    logic       irWr;
    logic       memRd;
    logic       memWr;
    logic       iorD;
    logic       regWr;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [2:0] aluSrcB;
    logic [4:0] aluCtrl;
    logic       illegalOp;
    logic [2:0] state;
  } outVec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_if bus();

  mc_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int testCount = 0;
  int failCount = 0;
  int memCycles = 0;
  int regWrPulses = 0;
  instrDesc_t tbl[$];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic outVec_t observe();
    outVec_t v;
    v.pcWr      = bus.PCWr;
    v.pcSrc     = bus.PCSrc;
    v.irWr      = bus.IRWr;
    v.memRd     = bus.MemRd;
    v.memWr     = bus.MemWr;
    v.iorD      = bus.IorD;
    v.regWr     = bus.RegWr;
    v.regDst    = bus.RegDst;
    v.memToReg  = bus.MemToReg;
    v.aluSrcA   = bus.AluSrcA;
    v.aluSrcB   = bus.AluSrcB;
    v.aluCtrl   = bus.AluCtrl;
    v.illegalOp = bus.IllegalOp;
    v.state     = bus.State;
    return v;
  endfunction

  function automatic outVec_t idleVec(input mcState_e st);
    outVec_t v = '0;
    v.aluCtrl = ALUOp_ADDU;
    v.state   = st;
    return v;
  endfunction

  // Outputs expected for one cycle of an instruction in phase st.
  function automatic outVec_t expectOut(input mcState_e st, input instrDesc_t d,
                                        input logic zero, input logic rdy);
    outVec_t v = idleVec(st);
    case (st)
      S_FETCH: begin
        v.memRd   = 1'b1;
        v.aluSrcB = 3'd1;
        v.irWr    = rdy;
        v.pcWr    = rdy;
      end
      S_DECODE: begin
        v.aluSrcB = 3'd4;
        if (d.kind == K_J) begin
          v.pcWr  = 1'b1;
          v.pcSrc = 2'd2;
        end
        if (d.kind == K_ILL) v.illegalOp = 1'b1;
      end
      S_EXEC: begin
        v.aluSrcA = 1'b1;
        v.aluSrcB = d.srcB;
        v.aluCtrl = d.alu;
        if (d.kind == K_BEQ || d.kind == K_BNE) begin
          v.pcWr  = zero;
          v.pcSrc = 2'd1;
        end
      end
      S_MEM: begin
        v.iorD  = 1'b1;
        v.memRd = (d.kind == K_LW);
        v.memWr = (d.kind == K_SW);
      end
      S_WB: begin
        v.regWr    = 1'b1;
        v.regDst   = (d.kind == K_R);
        v.memToReg = (d.kind == K_LW);
      end
      default: ;
    endcase
    return v;
  endfunction

  // zeroSel < 0: random Zero; memStall < 0: random MemReady, else MEM sees
  // memStall low cycles; abortAtExec asserts rst in the EXEC cycle.
  task automatic runInstr(input int idx, input int zeroSel, input int memStall, input bit abortAtExec);
    instrDesc_t d;
    mcState_e   steps[$];
    logic [5:0] fn;
    d = tbl[idx];
    fn = (d.op == 6'h00) ? d.funct : 6'($urandom);
    steps = '{S_FETCH, S_DECODE};
    if (d.kind != K_J && d.kind != K_ILL) steps.push_back(S_EXEC);
    if (d.kind == K_LW || d.kind == K_SW) steps.push_back(S_MEM);
    if (d.kind == K_R || d.kind == K_I || d.kind == K_LW) steps.push_back(S_WB);
    for (int i = 0; i < steps.size(); i++) begin
      int waited;
      bit done;
      waited = 0;
      done = 1'b0;
      while (!done) begin
        logic rdyIn, rdyEff, z;
        bit memStep;
        memStep = (steps[i] == S_FETCH || steps[i] == S_MEM);
        if (memStall >= 0) rdyIn = (steps[i] == S_MEM) ? (waited >= memStall) : 1'b1;
        else rdyIn = (waited >= 3) || ($urandom_range(0, 2) != 0);
        z = (zeroSel < 0) ? 1'($urandom) : 1'(zeroSel);
        rdyEff = WAIT_EN ? rdyIn : 1'b1;
        @(negedge clk);
        bus.Op       = (steps[i] == S_FETCH) ? 6'($urandom) : d.op;
        bus.Funct    = (steps[i] == S_FETCH) ? 6'($urandom) : fn;
        bus.Zero     = z;
        bus.MemReady = rdyIn;
        if (abortAtExec && steps[i] == S_EXEC) begin
          rst = 1'b1;
          #1;
          checkEq("rstInExec", 32'(observe()), 32'(idleVec(S_EXEC)));
          checkEq("rstInExecMemWr", 32'(bus.MemWr), 32'd0);
          return;
        end
        rst = 1'b0;
        #1;
        checkEq($sformatf("op%02h fn%02h st%0d", d.op, fn, steps[i]),
                32'(observe()), 32'(expectOut(steps[i], d, z, memStep ? rdyEff : 1'b1)));
        if (bus.State == 3'(S_MEM)) memCycles++;
        if (bus.RegWr) regWrPulses++;
        done = !memStep || rdyEff;
        waited++;
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus.Op = 6'h00;
    bus.Funct = 6'h00;
    bus.Zero = 1'b0;
    bus.MemReady = 1'b1;
    @(negedge clk);
    #1;
    checkEq("resetIdle", 32'(observe()), 32'(idleVec(S_FETCH)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{6'h00, 6'h20, K_R, ALUOp_ADD,  3'd0});
    tbl.push_back('{6'h00, 6'h21, K_R, ALUOp_ADDU, 3'd0});
    tbl.push_back('{6'h00, 6'h22, K_R, ALUOp_SUB,  3'd0});
    tbl.push_back('{6'h00, 6'h23, K_R, ALUOp_SUBU, 3'd0});
    tbl.push_back('{6'h00, 6'h24, K_R, ALUOp_AND,  3'd0});
    tbl.push_back('{6'h00, 6'h25, K_R, ALUOp_OR,   3'd0});
    tbl.push_back('{6'h00, 6'h2a, K_R, ALUOp_SLT,  3'd0});
    tbl.push_back('{6'h00, 6'h00, K_R, ALUOp_SLL,  3'd2});
    tbl.push_back('{6'h00, 6'h02, K_R, ALUOp_SRL,  3'd2});
    tbl.push_back('{6'h08, 6'h00, K_I, ALUOp_ADD,  3'd2});
    tbl.push_back('{6'h09, 6'h00, K_I, ALUOp_ADDU, 3'd2});
    tbl.push_back('{6'h0d, 6'h00, K_I, ALUOp_OR,   3'd3});
    tbl.push_back('{6'h23, 6'h00, K_LW, ALUOp_ADDU, 3'd2});
    tbl.push_back('{6'h2b, 6'h00, K_SW, ALUOp_ADDU, 3'd2});
    tbl.push_back('{6'h04, 6'h00, K_BEQ, ALUOp_EQL, 3'd0});
    tbl.push_back('{6'h05, 6'h00, K_BNE, ALUOp_BNE, 3'd0});
    tbl.push_back('{6'h02, 6'h00, K_J,   ALUOp_ADDU, 3'd0});
    tbl.push_back('{6'h3f, 6'h00, K_ILL, ALUOp_ADDU, 3'd0});
    tbl.push_back('{6'h0f, 6'h00, K_ILL, ALUOp_ADDU, 3'd0});
    tbl.push_back('{6'h00, 6'h3f, K_ILL, ALUOp_ADDU, 3'd0});
    tbl.push_back('{6'h00, 6'h08, K_ILL, ALUOp_ADDU, 3'd0});

    doReset();
    runInstr(I_ADDU, -1, -1, 1'b0);
    runInstr(I_BEQ, 1, -1, 1'b0);
    runInstr(I_BEQ, 0, -1, 1'b0);
    runInstr(I_BNE, 1, -1, 1'b0);
    runInstr(I_LW, -1, 0, 1'b0);

    memCycles = 0;
    regWrPulses = 0;
    runInstr(I_LW, -1, 3, 1'b0);
    checkEq("lwWaitMemCycles", 32'(memCycles), WAIT_EN ? 32'd4 : 32'd1);
    checkEq("lwWaitRegWr", 32'(regWrPulses), 32'd1);

    regWrPulses = 0;
    runInstr(I_ILL, -1, -1, 1'b0);
    checkEq("illegalNoRegWr", 32'(regWrPulses), 32'd0);

    runInstr(I_SW, -1, -1, 1'b1);
    runInstr(I_ADDU, -1, -1, 1'b0);

    for (int n = 0; n < 80; n++) begin
      runInstr(int'($urandom_range(0, tbl.size() - 1)), -1, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
